// File: rtl/rect_fill_writer_if.sv
// Command and framebuffer-write bundle for rect_fill_writer.
// The slave modport is the rasterizer's view; the master modport is the command/framebuffer side.
interface rect_fill_writer_if #(
   parameter int unsigned FB_WIDTH   = 320,
   parameter int unsigned FB_HEIGHT  = 240,
   parameter int unsigned COLOR_BITS = 8,
   parameter int unsigned X_BITS     = $clog2(FB_WIDTH),
   parameter int unsigned Y_BITS     = $clog2(FB_HEIGHT),
   parameter int unsigned ADDR_BITS  = $clog2(FB_WIDTH * FB_HEIGHT)
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [X_BITS-1:0]     cmd_x;
   logic [Y_BITS-1:0]     cmd_y;
   logic [X_BITS:0]       cmd_w;
   logic [Y_BITS:0]       cmd_h;
   logic [COLOR_BITS-1:0] cmd_color;

   logic                  wr_valid;
   logic                  wr_ready;
   logic [ADDR_BITS-1:0]  wr_addr;
   logic [COLOR_BITS-1:0] wr_data;

   logic                  busy;
   logic                  done;

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, wr_ready,
      output cmd_ready, wr_valid, wr_addr, wr_data, busy, done
   );

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, wr_ready,
      input  cmd_ready, wr_valid, wr_addr, wr_data, busy, done
   );
endinterface

// File: rtl/rect_fill_writer.sv
// Rectangle rasterizer: clips a fill command to the framebuffer and emits
// one (address, colour) write per handshake in row-major order, then pulses done.
module rect_fill_writer #(
   parameter int unsigned FB_WIDTH   = 320,
   parameter int unsigned FB_HEIGHT  = 240,
   parameter int unsigned COLOR_BITS = 8,
   parameter int unsigned X_BITS     = $clog2(FB_WIDTH),
   parameter int unsigned Y_BITS     = $clog2(FB_HEIGHT),
   parameter int unsigned ADDR_BITS  = $clog2(FB_WIDTH * FB_HEIGHT)
) (
   input logic               clk,
   input logic               rst,
   rect_fill_writer_if.slave bus
);
   localparam int unsigned CW = X_BITS + 1;
   localparam int unsigned RW = Y_BITS + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLIP   = 2'd1,
      DRAW   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t state;

   // Latched command
   logic [X_BITS-1:0]     x0;
   logic [Y_BITS-1:0]     y0;
   logic [CW-1:0]         w_req;
   logic [RW-1:0]         h_req;
   logic [COLOR_BITS-1:0] color;

   // Scan state
   logic [CW-1:0]         w_eff;
   logic [RW-1:0]         h_eff;
   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic [ADDR_BITS-1:0]  row_base;

   // Registered outputs
   logic                  cmd_ready_q;
   logic                  wr_valid_q;
   logic [ADDR_BITS-1:0]  wr_addr_q;
   logic [COLOR_BITS-1:0] wr_data_q;
   logic                  busy_q;
   logic                  done_q;

   // Clip arithmetic; widths carry one extra bit so FB_WIDTH/FB_HEIGHT fit without wrap
   logic                  x_off_c;
   logic                  y_off_c;
   logic [CW-1:0]         x_room_c;
   logic [RW-1:0]         y_room_c;
   logic [CW-1:0]         w_eff_c;
   logic [RW-1:0]         h_eff_c;
   logic                  empty_c;
   logic [ADDR_BITS-1:0]  base_c;

   always_comb begin
      x_off_c  = CW'(x0) >= CW'(FB_WIDTH);
      y_off_c  = RW'(y0) >= RW'(FB_HEIGHT);
      x_room_c = x_off_c ? '0 : CW'(FB_WIDTH) - CW'(x0);
      y_room_c = y_off_c ? '0 : RW'(FB_HEIGHT) - RW'(y0);
      w_eff_c  = (w_req < x_room_c) ? w_req : x_room_c;
      h_eff_c  = (h_req < y_room_c) ? h_req : y_room_c;
      empty_c  = x_off_c | y_off_c | (w_eff_c == '0) | (h_eff_c == '0);
      // Constant multiply reduces to shifts and adds in synthesis
      base_c   = ADDR_BITS'(y0) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(x0);
   end

   // Scan position decode
   logic                 col_last_c;
   logic                 row_last_c;
   logic [ADDR_BITS-1:0] next_base_c;

   always_comb begin
      col_last_c  = (col == w_eff - CW'(1));
      row_last_c  = (row == h_eff - RW'(1));
      next_base_c = row_base + ADDR_BITS'(FB_WIDTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cmd_ready_q <= 1'b1;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         x0          <= '0;
         y0          <= '0;
         w_req       <= '0;
         h_req       <= '0;
         color       <= '0;
         w_eff       <= '0;
         h_eff       <= '0;
         col         <= '0;
         row         <= '0;
         row_base    <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.cmd_valid && cmd_ready_q) begin
                  x0          <= bus.cmd_x;
                  y0          <= bus.cmd_y;
                  w_req       <= bus.cmd_w;
                  h_req       <= bus.cmd_h;
                  color       <= bus.cmd_color;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state       <= CLIP;
               end
            end

            CLIP: begin
               w_eff    <= w_eff_c;
               h_eff    <= h_eff_c;
               col      <= '0;
               row      <= '0;
               row_base <= base_c;
               if (empty_c) begin
                  done_q <= 1'b1;
                  state  <= FINISH;
               end else begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= base_c;
                  wr_data_q  <= color;
                  state      <= DRAW;
               end
            end

            // Address and data only move on an accepted write, so a stall holds them
            DRAW: begin
               if (bus.wr_ready) begin
                  if (col_last_c && row_last_c) begin
                     wr_valid_q <= 1'b0;
                     done_q     <= 1'b1;
                     state      <= FINISH;
                  end else if (col_last_c) begin
                     col       <= '0;
                     row       <= row + RW'(1);
                     row_base  <= next_base_c;
                     wr_addr_q <= next_base_c;
                  end else begin
                     col       <= col + CW'(1);
                     wr_addr_q <= wr_addr_q + ADDR_BITS'(1);
                  end
               end
            end

            FINISH: begin
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.wr_valid  = wr_valid_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   // A stalled write must be held unchanged until accepted
   a_no_retract: assert property (@(posedge clk) disable iff (rst)
      (wr_valid_q && !bus.wr_ready) |=> (wr_valid_q && $stable(wr_addr_q) && $stable(wr_data_q)));

   a_addr_range: assert property (@(posedge clk) disable iff (rst)
      wr_valid_q |-> (32'(wr_addr_q) < FB_WIDTH * FB_HEIGHT));

   a_done_quiet: assert property (@(posedge clk) disable iff (rst)
      done_q |-> (!wr_valid_q && !cmd_ready_q));
endmodule

// File: tb/tb_rect_fill_writer.sv
// Self-checking bench for rect_fill_writer: directed vector table, random commands
// against a pixel-enumeration model, and reset/back-to-back sequences.
module tb_rect_fill_writer;
   localparam int FBW   = 320;
   localparam int FBH   = 240;
   localparam int CB    = 8;
   localparam int XB    = $clog2(FBW);
   localparam int YB    = $clog2(FBH);
   localparam int WB    = XB + 1;
   localparam int HB    = YB + 1;
   localparam int BOUND = 4000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rect_fill_writer_if #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .COLOR_BITS(CB)) bus ();

   rect_fill_writer #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .COLOR_BITS(CB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int got_addr[$];
   int got_data[$];
   int exp_addr[$];

   typedef struct {
      int x, y, w, h, color, bp;
      int n, first, last;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Every on-screen pixel of the rectangle, visited top-to-bottom, left-to-right
   function automatic void model(input int x, input int y, input int w, input int h);
      exp_addr.delete();
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            if (x + c < FBW && y + r < FBH) exp_addr.push_back((y + r) * FBW + x + c);
   endfunction

   task automatic drive_cmd(input int x, input int y, input int w, input int h, input int color);
      bus.cmd_x     = XB'(x);
      bus.cmd_y     = YB'(y);
      bus.cmd_w     = WB'(w);
      bus.cmd_h     = HB'(h);
      bus.cmd_color = CB'(color);
      bus.cmd_valid = 1'b1;
   endtask

   task automatic issue(input int x, input int y, input int w, input int h, input int color);
      @(negedge clk);
      drive_cmd(x, y, w, h, color);
      chk("cmd_ready_idle", bus.cmd_ready, 1);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   // Watch one command from the cycle after its handshake (k=1) until done
   task automatic follow(input int bp, output int done_k, output int first_k, output int bad);
      bit stalled;
      int s_addr, s_data;
      got_addr.delete();
      got_data.delete();
      done_k  = -1;
      first_k = -1;
      bad     = 0;
      stalled = 1'b0;
      s_addr  = 0;
      s_data  = 0;
      for (int k = 1; k <= BOUND && done_k < 0; k++) begin
         @(negedge clk);
         if (bp == 0)      bus.wr_ready = 1'b1;
         else if (bp == 1) bus.wr_ready = ((k % 3) == 2);
         else              bus.wr_ready = 1'($urandom_range(0, 1));
         if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad |= 1;
         if (stalled && (bus.wr_valid !== 1'b1 || int'(bus.wr_addr) != s_addr ||
                         int'(bus.wr_data) != s_data)) bad |= 2;
         if (bus.done === 1'b1) begin
            done_k = k;
            if (bus.wr_valid !== 1'b0) bad |= 4;
         end else if (bus.wr_valid === 1'b1) begin
            if (first_k < 0) first_k = k;
            if (bus.wr_ready) begin
               got_addr.push_back(int'(bus.wr_addr));
               got_data.push_back(int'(bus.wr_data));
            end
         end
         stalled = (bus.wr_valid === 1'b1) && (bus.wr_ready === 1'b0);
         s_addr  = int'(bus.wr_addr);
         s_data  = int'(bus.wr_data);
      end
      if (done_k < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic verify(input string tag, input int color, input int done_k,
                         input int first_k, input int bad, input int bp);
      int idx, didx, n;
      idx  = -1;
      didx = -1;
      chk({tag, " count"}, got_addr.size(), exp_addr.size());
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++)
         if (idx < 0 && got_addr[i] != exp_addr[i]) idx = i;
      for (int i = 0; i < got_data.size(); i++)
         if (didx < 0 && got_data[i] != (color & 8'hFF)) didx = i;
      n_tests++;
      if (idx >= 0) begin
         n_fail++;
         $display("FAIL %s order: write %0d addr %0d expected %0d", tag, idx,
                  got_addr[idx], exp_addr[idx]);
      end
      n_tests++;
      if (didx >= 0) begin
         n_fail++;
         $display("FAIL %s data: write %0d data %0d expected %0d", tag, didx,
                  got_data[didx], color & 8'hFF);
      end
      chk({tag, " protocol_flags"}, bad, 0);
      chk({tag, " first_valid_cycle"}, first_k, (exp_addr.size() > 0) ? 2 : -1);
      if (bp == 0) chk({tag, " done_cycle"}, done_k, exp_addr.size() + 2);
      @(negedge clk);
      chk({tag, " ready_after"}, bus.cmd_ready, 1);
      chk({tag, " busy_after"}, bus.busy, 0);
      chk({tag, " done_single"}, bus.done, 0);
   endtask

   task automatic run_cmd(input string tag, input int x, input int y, input int w,
                          input int h, input int color, input int bp);
      int dk, fk, bad;
      model(x, y, w, h);
      issue(x, y, w, h, color);
      follow(bp, dk, fk, bad);
      verify(tag, color, dk, fk, bad, bp);
   endtask

   initial begin
      int hs, flag, x, y, w, h, bp, dk, fk, bad;

      // x, y, w, h, colour, backpressure, writes, first addr, last addr
      vecs[0]  = '{10, 5, 4, 3, 'hA5, 0, 12, 1610, 2253};
      vecs[1]  = '{10, 5, 4, 3, 'hA5, 1, 12, 1610, 2253};
      vecs[2]  = '{318, 239, 5, 2, 'h3C, 0, 2, 76798, 76799};
      vecs[3]  = '{10, 5, 0, 3, 'h11, 0, 0, 0, 0};
      vecs[4]  = '{320, 5, 4, 3, 'h22, 0, 0, 0, 0};
      vecs[5]  = '{0, 0, 5, 0, 'h33, 0, 0, 0, 0};
      vecs[6]  = '{7, 240, 3, 3, 'h44, 0, 0, 0, 0};
      vecs[7]  = '{0, 0, 320, 1, 'hFF, 0, 320, 0, 319};
      vecs[8]  = '{0, 239, 1023, 1, 'h01, 1, 320, 76480, 76799};
      vecs[9]  = '{5, 5, 1, 1, 'h7E, 2, 1, 1605, 1605};
      vecs[10] = '{511, 0, 4, 4, 'h55, 0, 0, 0, 0};
      vecs[11] = '{300, 230, 40, 20, 'h5A, 0, 200, 73900, 76799};

      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.wr_ready  = 1'b0;
      drive_cmd(0, 0, 0, 0, 0);
      bus.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset cmd_ready", bus.cmd_ready, 1);
      chk("reset wr_valid", bus.wr_valid, 0);
      chk("reset wr_addr", bus.wr_addr, 0);
      chk("reset wr_data", bus.wr_data, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset done", bus.done, 0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         run_cmd(tag, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color, vecs[i].bp);
         chk({tag, " table_count"}, got_addr.size(), vecs[i].n);
         if (vecs[i].n > 0) begin
            chk({tag, " table_first"}, (got_addr.size() > 0) ? got_addr[0] : -1, vecs[i].first);
            chk({tag, " table_last"}, (got_addr.size() > 0) ? got_addr[got_addr.size()-1] : -1,
                vecs[i].last);
         end
      end

      // Random commands biased toward the right/bottom edges
      for (int i = 0; i < 24; i++) begin
         x  = ($urandom % 2) ? $urandom_range(FBW - 30, FBW + 5) : $urandom_range(0, FBW + 15);
         y  = ($urandom % 2) ? $urandom_range(FBH - 12, FBH + 3) : $urandom_range(0, FBH + 10);
         w  = $urandom_range(0, 40);
         h  = $urandom_range(0, 10);
         bp = ($urandom % 2) ? 0 : 2;
         run_cmd($sformatf("rand%0d", i), x, y, w, h, $urandom_range(0, 255), bp);
      end

      // Back-to-back: second command held on the bus while the first runs
      @(negedge clk);
      drive_cmd(100, 50, 3, 2, 'h11);
      chk("b2b ready_a", bus.cmd_ready, 1);
      @(posedge clk);
      #1 drive_cmd(5, 7, 2, 2, 'h22);
      model(100, 50, 3, 2);
      follow(0, dk, fk, bad);
      verify("b2b_a", 'h11, dk, fk, bad, 0);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      model(5, 7, 2, 2);
      follow(0, dk, fk, bad);
      verify("b2b_b", 'h22, dk, fk, bad, 0);

      // Reset after the fifth accepted write
      issue(10, 5, 4, 3, 'hA5);
      hs = 0;
      for (int k = 0; k < 40 && hs < 5; k++) begin
         @(negedge clk);
         bus.wr_ready = 1'b1;
         if (bus.wr_valid === 1'b1) hs++;
      end
      chk("rst_mid handshakes", hs, 5);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid wr_valid", bus.wr_valid, 0);
      chk("rst_mid busy", bus.busy, 0);
      chk("rst_mid cmd_ready", bus.cmd_ready, 1);
      chk("rst_mid done", bus.done, 0);
      flag = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.wr_valid !== 1'b0 || bus.busy !== 1'b0) flag = 1;
      end
      chk("rst_mid quiet_after", flag, 0);

      // Reset and command in the same cycle: command dropped
      @(negedge clk);
      rst = 1'b1;
      drive_cmd(10, 5, 4, 3, 'hA5);
      @(negedge clk);
      rst           = 1'b0;
      bus.cmd_valid = 1'b0;
      chk("rst_cmd busy", bus.busy, 0);
      chk("rst_cmd ready", bus.cmd_ready, 1);
      flag = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.wr_valid !== 1'b0) flag = 1;
      end
      chk("rst_cmd not_accepted", flag, 0);

      // Idle machine still works after the reset sequences
      run_cmd("post_rst", 318, 239, 5, 2, 'h3C, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
